// File: rtl/sdram_com_rx_pkg.sv
// Register map, bit positions and FSM encoding shared by the SDRAM-to-Nios receive controller.
package sdram_com_rx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_EMPTY     = 8;
  localparam int ST_FULL      = 9;
  localparam int ST_OVERFLOW  = 10;
  localparam int ST_UNDERFLOW = 11;
  localparam int ST_STATE_LO  = 12;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int TS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } rx_state_t;

  function automatic logic [31:0] status_word(input logic [6:0] count, input logic empty,
                                              input logic full, input logic overflow,
                                              input logic underflow, input rx_state_t state);
    logic [31:0] w;
    w                     = '0;
    w[6:0]                = count;
    w[ST_EMPTY]           = empty;
    w[ST_FULL]            = full;
    w[ST_OVERFLOW]        = overflow;
    w[ST_UNDERFLOW]       = underflow;
    w[ST_STATE_LO +: 2]   = state;
    return w;
  endfunction

endpackage

// File: rtl/sdram_com_rx_fifo.sv
// Synchronous FIFO with flush. The head is presented combinationally so the caller can
// register a popped sample in the same cycle as the pop.
module sdram_com_rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     empty,
  output logic                     full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (do_push && !do_pop)
      count_next = count_reg + (ADDR_W + 1)'(1);
    else if (!do_push && do_pop)
      count_next = count_reg - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/sdram_com_rx_ctrl.sv
// Receive controller: producer valid/ready into a FIFO, FSM, Avalon-MM register file and irq.
// Build macro SDRAM_COM_RX_TIMESTAMP_EN tags each sample with a 16-bit free-running stamp.
module sdram_com_rx_ctrl
  import sdram_com_rx_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int IRQ_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int ADDR_W = $clog2(DEPTH);
`ifdef SDRAM_COM_RX_TIMESTAMP_EN
  localparam int FIFO_W = DATA_W + TS_W;
`else
  localparam int FIFO_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_CNT = (ADDR_W + 1)'(IRQ_THRESH);

  rx_state_t       state_reg, state_next;
  logic            in_ready_reg, in_ready_next;
  logic            enable_reg, enable_next, irq_en_reg, irq_en_next, clear_reg, clear_next;
  logic            overflow_reg, overflow_next, underflow_reg, underflow_next;
  logic            irq_reg, irq_next;
  logic [31:0]     readdata_reg, readdata_next, data_word;
  logic            ctrl_write, data_read, push, pop;
  logic [FIFO_W-1:0] fifo_wr_data, fifo_rd_data;
  logic [ADDR_W:0] count, count_next;
  logic            empty, full;
  logic            unused_writedata;

  assign unused_writedata = ^writedata[31:3];

  // A read in the same cycle as a write takes the bus; the write is dropped.
  assign ctrl_write = write & ~read & (address == REG_CTRL);
  assign data_read  = read & (address == REG_DATA);
  assign push       = in_valid & in_ready_reg & ~clear_reg;
  assign pop        = data_read & ~empty;

`ifdef SDRAM_COM_RX_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;
  always_ff @(posedge clk) begin
    if (reset)
      ts_reg <= '0;
    else
      ts_reg <= ts_reg + TS_W'(1);
  end
  assign fifo_wr_data = {ts_reg, in_data};
  assign data_word    = {fifo_rd_data[FIFO_W-1:DATA_W], 16'(fifo_rd_data[DATA_W-1:0])};
`else
  assign fifo_wr_data = in_data;
  assign data_word    = {16'b0, 16'(fifo_rd_data)};
`endif

  sdram_com_rx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .clear      (clear_reg),
    .wr_data    (fifo_wr_data),
    .rd_data    (fifo_rd_data),
    .count      (count),
    .count_next (count_next),
    .empty      (empty),
    .full       (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= in_ready_next;
    end
  end

  // State follows the post-edge enable and fill level, so a disable or a pop lands next cycle.
  always_comb begin
    state_next = RUN;
    if (!enable_next)
      state_next = IDLE;
    else if (count_next == DEPTH_CNT)
      state_next = FULL;
  end

  always_comb begin
    in_ready_next = (state_next == RUN);
  end

  always_comb begin
    enable_next = enable_reg;
    irq_en_next = irq_en_reg;
    clear_next  = 1'b0;
    if (ctrl_write) begin
      enable_next = writedata[CTRL_ENABLE];
      irq_en_next = writedata[CTRL_IRQ_EN];
      clear_next  = writedata[CTRL_CLEAR];
    end
  end

  always_comb begin
    overflow_next  = overflow_reg | (in_valid & (state_reg == FULL));
    underflow_next = underflow_reg | (data_read & empty);
    if (clear_reg) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    irq_next = irq_en_reg & ((count >= THRESH_CNT) | overflow_reg);
  end

  always_comb begin
    readdata_next = readdata_reg;
    if (read) begin
      case (address)
        REG_DATA:   readdata_next = empty ? 32'b0 : data_word;
        REG_STATUS: readdata_next = status_word(7'(count), empty, full, overflow_reg,
                                                underflow_reg, state_reg);
        REG_CTRL:   readdata_next = {29'b0, irq_en_reg, 1'b0, enable_reg};
        default:    readdata_next = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_reg    <= 1'b0;
      irq_en_reg    <= 1'b0;
      clear_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      irq_reg       <= 1'b0;
      readdata_reg  <= '0;
    end else begin
      enable_reg    <= enable_next;
      irq_en_reg    <= irq_en_next;
      clear_reg     <= clear_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      irq_reg       <= irq_next;
      readdata_reg  <= readdata_next;
    end
  end

  assign in_ready = in_ready_reg;
  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule

// File: doc/sdram_com_rx_ctrl.md
Name: sdram_com_rx_ctrl

Overview:
- Flow-controlled receive controller for the 16-bit SDRAM-to-Nios communication data path.
- The producer pushes samples through a valid/ready handshake into a small FIFO.
- The Nios reads the samples, status and control through a 4-word Avalon-MM slave with 1-cycle registered read latency.
- Replaces raw unsynchronised port polling, so no samples are lost or duplicated.

Parameters:
- DATA_W, 16, sample width; 16 or less.
- DEPTH, 8, FIFO depth; power of 2, range 2..64.
- IRQ_THRESH, 4, fill level that raises irq when enabled; range 1..DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  producer sample.
- in_valid  in  1  producer sample valid.
- in_ready  out  1  controller can accept a sample.
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- irq  out  1  level interrupt to Nios.

Behaviour:
- Reset, evaluated at the clk edge:
  - readdata=0, in_ready=0, irq=0.
  - FIFO emptied, count=0.
  - Control register = 0; overflow flag cleared; state=IDLE.
- Push: occurs when in_valid & in_ready. in_ready = (state==RUN), a registered decode of the next state.
- State machine, 3 states:
  - IDLE: entered when ctrl.enable=0.
  - RUN: enable=1 and count<DEPTH.
  - FULL: enable=1 and count==DEPTH.
  - Transitions are evaluated every cycle from next_count and enable.
  - FULL→RUN on the cycle after a pop.
  - Any state→IDLE on the cycle after enable is written 0. Data already in the FIFO is kept.
- Overflow: in_valid=1 while in FULL sets a sticky overflow flag. The sample is dropped and in_ready stays 0.
- Register map, all reads 1-cycle latency:
  - 0 DATA, read-only:
    - A read pops the head entry; readdata = {16'b0, head}, zero-extended from DATA_W.
    - A read while empty returns 0, does not change count, and sets the sticky underflow flag.
  - 1 STATUS, read-only:
    - [6:0] count.
    - [8] empty, [9] full, [10] overflow, [11] underflow, [13:12] state encoding (IDLE=0, RUN=1, FULL=2).
    - Other bits 0.
  - 2 CTRL, read/write:
    - [0] enable, [2] irq_en.
    - [1] clear: write-only and self-clearing. Flushes the FIFO, zeroes count and clears overflow/underflow one cycle after the write.
    - Reads return {29'b0, irq_en, 1'b0, enable}.
  - 3: reads 0; writes ignored.
- Simultaneous push and pop: count unchanged, pointers both advance. This is legal while FULL: the pop frees a slot and in_ready goes high next cycle, so there is no same-cycle push in FULL.
- Clear coinciding with a push or pop: clear wins; the push is discarded and the pop returns the pre-clear head.
- Read and write in the same cycle: read wins; the write is ignored.
- Pointers wrap modulo DEPTH. count is ADDR_W+1 bits wide.
- irq, registered: irq = irq_en & ((count >= IRQ_THRESH) | overflow). Deasserts the cycle after the condition drops.
- Reset asserted mid-transfer discards all FIFO contents; the producer sees in_ready=0 on the next cycle.

Optional Feature:
- SDRAM_COM_RX_TIMESTAMP_EN, when defined:
  - A 16-bit free-running counter is added; it resets to 0 and increments every clk, wrapping at 0xFFFF.
  - Each pushed sample stores the counter value alongside it.
  - A DATA read returns {timestamp, sample}.
- When undefined: no counter, FIFO width is DATA_W, and DATA[31:16]=0.

Decomposition:
- Package sdram_com_rx_pkg:
  - Register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2).
  - STATUS and CTRL bit positions.
  - State enum rx_state_t {IDLE, RUN, FULL}.
- Sub-module sdram_com_rx_fifo:
  - Parameterised width/depth synchronous FIFO with push, pop, clear, count, empty and full.
  - The top level holds the FSM, the register file and irq.

Test Plan:
- Reset, then write CTRL=1, then push 0x1234, 0xABCD → STATUS count=2, state=RUN. Two DATA reads return 0x00001234 then 0x0000ABCD; count=0, empty=1.
- Push 9 samples with DEPTH=8 → in_ready=0 after 8; STATUS full=1, overflow=1, state=FULL. One pop → in_ready=1 the following cycle.
- Read DATA while empty → readdata=0, count stays 0, STATUS[11]=1. Write CTRL clear → STATUS[11:10]=0.
- CTRL=5, push 4 samples → irq=1 on the cycle after the 4th push; a pop to 3 → irq=0 one cycle later.
- Push on the same cycle as a CTRL clear write → count=0 afterwards; the sample is lost. Reset asserted with 5 entries → count=0, readdata=0, in_ready=0.
- With SDRAM_COM_RX_TIMESTAMP_EN: reset, then push at cycle 10 and cycle 25 after reset → DATA[31:16] values differ by exactly 15.
